// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite encodings, timer register offsets and byte-lane helper.
package ahb_lite_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE  = 3'd0,
    HSIZE_HALF  = 3'd1,
    HSIZE_WORD  = 3'd2,
    HSIZE_DWORD = 3'd3
  } hsize_e;

  localparam logic [11:0] TMR_CTRL     = 12'h000;
  localparam logic [11:0] TMR_PRESCALE = 12'h008;
  localparam logic [11:0] TMR_COUNT    = 12'h010;
  localparam logic [11:0] TMR_COMPARE  = 12'h018;
  localparam logic [11:0] TMR_STATUS   = 12'h020;

  localparam int CTRL_EN          = 0;
  localparam int CTRL_IRQ_EN      = 1;
  localparam int CTRL_AUTO_RELOAD = 2;

  // Lanes touched by a transfer; anything reaching past byte 7 (misaligned or
  // oversize) is simply cut off at the top of the dword.
  function automatic logic [7:0] lane_mask(input logic [2:0] size,
                                           input logic [2:0] offset);
    logic [15:0] base;
    case (size)
      3'd0:    base = 16'h0001;
      3'd1:    base = 16'h0003;
      3'd2:    base = 16'h000F;
      default: base = 16'h00FF;
    endcase
    lane_mask = 8'(base << offset);
  endfunction

endpackage

// File: rtl/ahb_lite_slave_if.sv
// Generic AHB-Lite slave front end: captures the address phase and presents
// data-phase strobes, register offset and byte-lane mask to the register file.
module ahb_lite_slave_if
  import ahb_lite_pkg::*;
#(
  parameter int HADDR_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   HSEL,
  input  logic                   HREADY,
  input  logic [1:0]             HTRANS,
  input  logic [HADDR_WIDTH-1:0] HADDR,
  input  logic [2:0]             HSIZE,
  input  logic                   HWRITE,
  output logic                   wr_en,
  output logic                   rd_en,
  output logic [11:0]            reg_addr,
  output logic [7:0]             byte_mask
);

  logic        acc;
  logic        valid_p1;
  logic        write_p1;
  logic [11:0] addr_p1;
  logic [2:0]  size_p1;

  // The decoder owns the upper address bits; HTRANS[0] only separates NONSEQ/SEQ.
  logic unused_bits;
  assign unused_bits = ^{HADDR[HADDR_WIDTH-1:12], HTRANS[0]};

  assign acc = HSEL & HREADY & HTRANS[1];

  // Address phase -> data phase register
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_p1 <= 1'b0;
      write_p1 <= 1'b0;
      addr_p1  <= '0;
      size_p1  <= '0;
    end else begin
      valid_p1 <= acc;
      if (acc) begin
        write_p1 <= HWRITE;
        addr_p1  <= HADDR[11:0];
        size_p1  <= HSIZE;
      end
    end
  end

  assign wr_en     = valid_p1 & write_p1;
  assign rd_en     = valid_p1 & ~write_p1;
  assign reg_addr  = addr_p1;
  assign byte_mask = lane_mask(size_p1, addr_p1[2:0]);

endmodule

// File: rtl/ahb_lite_timer.sv
// AHB-Lite 64-bit free-running timer with prescaler, compare match,
// auto-reload and a level interrupt.
module ahb_lite_timer
  import ahb_lite_pkg::*;
#(
  parameter int HADDR_WIDTH    = 32,
  parameter int HDATA_WIDTH    = 64,
  parameter int PRESCALE_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [HADDR_WIDTH-1:0] HADDR,
  input  logic [1:0]             HTRANS,
  input  logic [2:0]             HSIZE,
  input  logic                   HWRITE,
  input  logic [HDATA_WIDTH-1:0] HWDATA,
  output logic [HDATA_WIDTH-1:0] HRDATA,
  input  logic                   HREADY,
  output logic                   HRESP,
  input  logic                   HSEL,
  output logic                   HREADYOUT,
  output logic                   timer_irq
);

  localparam logic [8:0] IDX_CTRL     = TMR_CTRL[11:3];
  localparam logic [8:0] IDX_PRESCALE = TMR_PRESCALE[11:3];
  localparam logic [8:0] IDX_COUNT    = TMR_COUNT[11:3];
  localparam logic [8:0] IDX_COMPARE  = TMR_COMPARE[11:3];
  localparam logic [8:0] IDX_STATUS   = TMR_STATUS[11:3];

  logic                      wr_en;
  logic                      rd_en;
  logic [11:0]               reg_addr;
  logic [7:0]                byte_mask;

  logic [2:0]                ctrl;
  logic [PRESCALE_WIDTH-1:0] prescale;
  logic [PRESCALE_WIDTH-1:0] pdiv;
  logic [63:0]               count;
  logic [63:0]               compare;
  logic                      match;

  logic                      wr_ctrl, wr_prescale, wr_count, wr_compare, wr_status;
  logic [2:0]                ctrl_wr;
  logic [PRESCALE_WIDTH-1:0] prescale_wr;
  logic [63:0]               count_wr, compare_wr;
  logic                      tick, at_compare, status_clear;

  // Only dword-granular offsets are decoded; the low bits are folded into byte_mask.
  logic unused_bits;
  assign unused_bits = ^reg_addr[2:0];

  function automatic logic [63:0] merge_bytes(input logic [63:0] cur,
                                              input logic [63:0] wdata,
                                              input logic [7:0]  mask);
    logic [63:0] res;
    res = cur;
    for (int b = 0; b < 8; b++) begin
      if (mask[b]) res[8*b +: 8] = wdata[8*b +: 8];
    end
    return res;
  endfunction

  ahb_lite_slave_if #(
    .HADDR_WIDTH(HADDR_WIDTH)
  ) u_if (
    .clk      (clk),
    .reset    (reset),
    .HSEL     (HSEL),
    .HREADY   (HREADY),
    .HTRANS   (HTRANS),
    .HADDR    (HADDR),
    .HSIZE    (HSIZE),
    .HWRITE   (HWRITE),
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .reg_addr (reg_addr),
    .byte_mask(byte_mask)
  );

  assign wr_ctrl      = wr_en && (reg_addr[11:3] == IDX_CTRL);
  assign wr_prescale  = wr_en && (reg_addr[11:3] == IDX_PRESCALE);
  assign wr_count     = wr_en && (reg_addr[11:3] == IDX_COUNT);
  assign wr_compare   = wr_en && (reg_addr[11:3] == IDX_COMPARE);
  assign wr_status    = wr_en && (reg_addr[11:3] == IDX_STATUS);
  assign status_clear = wr_status && byte_mask[0] && HWDATA[0];

  assign tick       = ctrl[CTRL_EN] && (pdiv == prescale);
  assign at_compare = (count == compare);

  // Byte-merged write values for each register
  always_comb begin
    ctrl_wr     = 3'(merge_bytes({61'd0, ctrl}, HWDATA, byte_mask));
    prescale_wr = PRESCALE_WIDTH'(merge_bytes({{(64-PRESCALE_WIDTH){1'b0}}, prescale},
                                              HWDATA, byte_mask));
    count_wr    = merge_bytes(count, HWDATA, byte_mask);
    compare_wr  = merge_bytes(compare, HWDATA, byte_mask);
  end

  // Software-only configuration registers
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl     <= '0;
      prescale <= '0;
      compare  <= '0;
    end else begin
      if (wr_ctrl)     ctrl     <= ctrl_wr;
      if (wr_prescale) prescale <= prescale_wr;
      if (wr_compare)  compare  <= compare_wr;
    end
  end

  // Prescaler divider; reconfiguring restarts the current period
  always_ff @(posedge clk) begin
    if (reset)                      pdiv <= '0;
    else if (wr_ctrl || wr_prescale) pdiv <= '0;
    else if (tick)                  pdiv <= '0;
    else if (ctrl[CTRL_EN])         pdiv <= pdiv + PRESCALE_WIDTH'(1);
    else                            pdiv <= '0;
  end

  // Counter; a bus write wins over the tick and drops that increment
  always_ff @(posedge clk) begin
    if (reset)        count <= '0;
    else if (wr_count) count <= count_wr;
    else if (tick) begin
      if (ctrl[CTRL_AUTO_RELOAD] && at_compare) count <= '0;
      else                                      count <= count + 64'd1;
    end
  end

  // Match flag; a fresh hardware match beats a simultaneous W1C
  always_ff @(posedge clk) begin
    if (reset)                   match <= 1'b0;
    else if (tick && at_compare) match <= 1'b1;
    else if (status_clear)       match <= 1'b0;
  end

  // Data-phase read mux from the registered offset
  always_comb begin
    HRDATA = '0;
    if (rd_en) begin
      case (reg_addr[11:3])
        IDX_CTRL:     HRDATA = {61'd0, ctrl};
        IDX_PRESCALE: HRDATA = {{(64-PRESCALE_WIDTH){1'b0}}, prescale};
        IDX_COUNT:    HRDATA = count;
        IDX_COMPARE:  HRDATA = compare;
        IDX_STATUS:   HRDATA = {63'd0, match};
        default:      HRDATA = '0;
      endcase
    end
  end

  assign timer_irq = match & ctrl[CTRL_IRQ_EN];
  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;

endmodule

// File: tb/tb_ahb_lite_timer.sv
// Self-checking bench for ahb_lite_timer: register table plus timed sequences,
// with read data checked through a scoreboard queue.
module tb_ahb_lite_timer;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic        HWRITE;
  logic [63:0] HWDATA;
  logic [63:0] HRDATA;
  logic        HREADY;
  logic        HRESP;
  logic        HSEL;
  logic        HREADYOUT;
  logic        timer_irq;

  ahb_lite_timer dut (
    .clk      (clk),
    .reset    (reset),
    .HADDR    (HADDR),
    .HTRANS   (HTRANS),
    .HSIZE    (HSIZE),
    .HWRITE   (HWRITE),
    .HWDATA   (HWDATA),
    .HRDATA   (HRDATA),
    .HREADY   (HREADY),
    .HRESP    (HRESP),
    .HSEL     (HSEL),
    .HREADYOUT(HREADYOUT),
    .timer_irq(timer_irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sel;
    logic [1:0]  trans;
    logic        wr;
    logic [11:0] addr;
    logic [2:0]  size;
    logic [63:0] wdata;
  } op_t;

  typedef struct {
    string       name;
    bit          use_model;
    logic [11:0] addr;
    logic [63:0] exp;
  } sb_t;

  typedef struct {
    bit          wr;
    logic [11:0] addr;
    logic [2:0]  size;
    logic [63:0] wdata;
    logic [63:0] exp;
    string       name;
  } vec_t;

  sb_t  sb[$];
  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference state
  logic [2:0]  m_ctrl;
  logic [15:0] m_pre;
  logic [15:0] m_pdiv;
  logic [63:0] m_count;
  logic [63:0] m_cmp;
  logic        m_match;

  op_t dp;
  bit  dp_act;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] tb_lanes(input logic [2:0] sz, input logic [2:0] a);
    int n;
    int lo;
    logic [7:0] m;
    n  = (sz >= 3'd3) ? 8 : (1 << sz);
    lo = int'(a);
    m  = '0;
    for (int b = 0; b < 8; b++) if (b >= lo && b < lo + n) m[b] = 1'b1;
    return m;
  endfunction

  function automatic logic [63:0] tb_merge(input logic [63:0] cur, input logic [63:0] w,
                                           input logic [7:0] m);
    logic [63:0] r;
    r = cur;
    for (int b = 0; b < 8; b++) if (m[b]) r[b*8 +: 8] = w[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [63:0] reg_val(input logic [8:0] idx);
    case (idx)
      9'd0:    return {61'd0, m_ctrl};
      9'd1:    return {48'd0, m_pre};
      9'd2:    return m_count;
      9'd3:    return m_cmp;
      9'd4:    return {63'd0, m_match};
      default: return 64'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_ctrl = '0; m_pre = '0; m_pdiv = '0; m_count = '0; m_cmp = '0; m_match = 1'b0;
  endtask

  // Advance the reference by one clock edge; d is the op whose data phase ends here.
  task automatic model_edge(input op_t d, input bit act);
    bit          tick, eq, w;
    logic [8:0]  idx;
    logic [7:0]  m;
    logic [63:0] v;
    logic [15:0] n_pdiv;
    logic [63:0] n_count;
    logic        n_match;
    tick = m_ctrl[0] && (m_pdiv == m_pre);
    eq   = (m_count == m_cmp);
    w    = act && d.wr;
    idx  = d.addr[11:3];
    m    = tb_lanes(d.size, d.addr[2:0]);
    v    = tb_merge(reg_val(idx), d.wdata, m);
    if (w && (idx == 9'd0 || idx == 9'd1)) n_pdiv = '0;
    else if (tick)                         n_pdiv = '0;
    else if (m_ctrl[0])                    n_pdiv = m_pdiv + 16'd1;
    else                                   n_pdiv = '0;
    n_count = m_count;
    if (w && idx == 9'd2) n_count = v;
    else if (tick)        n_count = (m_ctrl[2] && eq) ? 64'd0 : m_count + 64'd1;
    n_match = m_match;
    if (tick && eq) n_match = 1'b1;
    else if (w && idx == 9'd4 && m[0] && d.wdata[0]) n_match = 1'b0;
    if (w && idx == 9'd0) m_ctrl = v[2:0];
    if (w && idx == 9'd1) m_pre  = v[15:0];
    if (w && idx == 9'd3) m_cmp  = v;
    m_pdiv = n_pdiv; m_count = n_count; m_match = n_match;
  endtask

  // One bus cycle: finish the previous data phase and drive a new address phase.
  task automatic cyc(input op_t op, input string nm, input bit use_model, input logic [63:0] exp);
    sb_t e;
    bit  acc;
    HWDATA = dp.wdata;
    if (dp_act && !dp.wr) begin
      if (sb.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL scoreboard_empty: got read data %h expected a queued entry", HRDATA);
      end else begin
        e = sb.pop_front();
        check(e.name, HRDATA, e.use_model ? reg_val(e.addr[11:3]) : e.exp);
      end
    end else if (!dp_act) begin
      check("hrdata_idle", HRDATA, 64'd0);
    end
    check("timer_irq", {63'd0, timer_irq}, {63'd0, m_match & m_ctrl[1]});
    check("hreadyout", {63'd0, HREADYOUT}, 64'd1);
    check("hresp", {63'd0, HRESP}, 64'd0);
    HSEL   = op.sel;
    HTRANS = op.trans;
    HWRITE = op.wr;
    HADDR  = {20'h80003, op.addr};
    HSIZE  = op.size;
    acc    = op.sel && HREADY && op.trans[1];
    if (acc && !op.wr) begin
      e.name = nm; e.use_model = use_model; e.addr = op.addr; e.exp = exp;
      sb.push_back(e);
    end
    @(posedge clk);
    model_edge(dp, dp_act);
    dp     = op;
    dp_act = acc;
    #1;
  endtask

  function automatic op_t mk(input logic sel, input logic [1:0] tr, input logic wr,
                             input logic [11:0] a, input logic [2:0] sz, input logic [63:0] wd);
    op_t o;
    o.sel = sel; o.trans = tr; o.wr = wr; o.addr = a; o.size = sz; o.wdata = wd;
    return o;
  endfunction

  task automatic wr(input logic [11:0] a, input logic [63:0] d);
    cyc(mk(1'b1, 2'b10, 1'b1, a, 3'd3, d), "", 1'b0, 64'd0);
  endtask

  task automatic rd_m(input string nm, input logic [11:0] a);
    cyc(mk(1'b1, 2'b10, 1'b0, a, 3'd3, 64'd0), nm, 1'b1, 64'd0);
  endtask

  task automatic rd_c(input string nm, input logic [11:0] a, input logic [63:0] exp);
    cyc(mk(1'b1, 2'b10, 1'b0, a, 3'd3, 64'd0), nm, 1'b0, exp);
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) cyc(mk(1'b0, 2'b00, 1'b0, 12'h0, 3'd0, 64'd0), "", 1'b0, 64'd0);
  endtask

  initial begin
    bit found;
    reset = 1'b1; HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HADDR = '0;
    HSIZE = '0; HWDATA = '0; HREADY = 1'b1;
    dp = mk(1'b0, 2'b00, 1'b0, 12'h0, 3'd0, 64'd0);
    dp_act = 1'b0;
    repeat (3) @(posedge clk);
    model_reset();
    #1;
    reset = 1'b0;

    // Register table, CTRL.EN kept 0 so every expectation is a constant
    tbl.push_back('{1'b0, 12'h000, 3'd3, 64'd0, 64'd0, "rst_ctrl"});
    tbl.push_back('{1'b0, 12'h008, 3'd3, 64'd0, 64'd0, "rst_prescale"});
    tbl.push_back('{1'b0, 12'h010, 3'd3, 64'd0, 64'd0, "rst_count"});
    tbl.push_back('{1'b0, 12'h018, 3'd3, 64'd0, 64'd0, "rst_compare"});
    tbl.push_back('{1'b0, 12'h020, 3'd3, 64'd0, 64'd0, "rst_status"});
    tbl.push_back('{1'b1, 12'h000, 3'd3, 64'h0000_0000_0000_00F0, 64'd0, ""});
    tbl.push_back('{1'b0, 12'h000, 3'd3, 64'd0, 64'd0, "ctrl_upper_zero"});
    tbl.push_back('{1'b1, 12'h008, 3'd3, 64'h0000_0000_0001_2345, 64'd0, ""});
    tbl.push_back('{1'b0, 12'h008, 3'd3, 64'd0, 64'h0000_0000_0000_2345, "prescale_trunc"});
    tbl.push_back('{1'b1, 12'h018, 3'd3, 64'h0123_4567_89AB_CDEF, 64'd0, ""});
    tbl.push_back('{1'b0, 12'h018, 3'd3, 64'd0, 64'h0123_4567_89AB_CDEF, "compare_b2b"});
    tbl.push_back('{1'b1, 12'h01A, 3'd0, 64'hFFFF_FFFF_FF55_FFFF, 64'd0, ""});
    tbl.push_back('{1'b0, 12'h018, 3'd3, 64'd0, 64'h0123_4567_8955_CDEF, "compare_byte2"});
    tbl.push_back('{1'b1, 12'h01C, 3'd1, 64'h1111_BEEF_2222_3333, 64'd0, ""});
    tbl.push_back('{1'b0, 12'h018, 3'd3, 64'd0, 64'h0123_BEEF_8955_CDEF, "compare_half"});
    tbl.push_back('{1'b1, 12'h018, 3'd5, 64'hA5A5_A5A5_A5A5_A5A5, 64'd0, ""});
    tbl.push_back('{1'b0, 12'h018, 3'd3, 64'd0, 64'hA5A5_A5A5_A5A5_A5A5, "compare_oversize"});
    tbl.push_back('{1'b1, 12'h01C, 3'd3, 64'h7777_6666_5555_4444, 64'd0, ""});
    tbl.push_back('{1'b0, 12'h018, 3'd3, 64'd0, 64'h7777_6666_A5A5_A5A5, "compare_misaligned"});
    tbl.push_back('{1'b1, 12'h028, 3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, ""});
    tbl.push_back('{1'b0, 12'h028, 3'd3, 64'd0, 64'd0, "unmapped_28"});
    tbl.push_back('{1'b0, 12'h800, 3'd3, 64'd0, 64'd0, "unmapped_800"});
    tbl.push_back('{1'b1, 12'h010, 3'd3, 64'h0000_0000_0000_0042, 64'd0, ""});
    tbl.push_back('{1'b0, 12'h010, 3'd3, 64'd0, 64'h0000_0000_0000_0042, "count_rw"});
    tbl.push_back('{1'b1, 12'h020, 3'd3, 64'h0000_0000_0000_0001, 64'd0, ""});
    tbl.push_back('{1'b0, 12'h020, 3'd3, 64'd0, 64'd0, "status_w1c_idle"});
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].wr) cyc(mk(1'b1, 2'b10, 1'b1, tbl[i].addr, tbl[i].size, tbl[i].wdata), "", 1'b0, 64'd0);
      else           cyc(mk(1'b1, 2'b10, 1'b0, tbl[i].addr, tbl[i].size, 64'd0), tbl[i].name, 1'b0, tbl[i].exp);
    end

    // Unselected and IDLE writes must not land
    cyc(mk(1'b0, 2'b10, 1'b1, 12'h010, 3'd3, 64'hDEAD), "", 1'b0, 64'd0);
    cyc(mk(1'b1, 2'b00, 1'b1, 12'h010, 3'd3, 64'hBEEF), "", 1'b0, 64'd0);
    rd_c("count_no_ghost_write", 12'h010, 64'h42);

    // Prescaled counting
    wr(12'h008, 64'd3);
    wr(12'h010, 64'd0);
    wr(12'h018, 64'hFFFF_0000_0000_0000);
    wr(12'h000, 64'd1);
    idle_n(40);
    rd_m("count_prescale3", 12'h010);

    // Compare match with auto-reload and interrupt
    wr(12'h000, 64'd0);
    wr(12'h008, 64'd0);
    wr(12'h018, 64'd5);
    wr(12'h010, 64'd0);
    wr(12'h020, 64'd1);
    wr(12'h000, 64'd7);
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (m_match) begin found = 1'b1; break; end
      idle_n(1);
    end
    if (!found) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_match: got no match within 30 cycles expected one");
    end
    rd_c("status_match", 12'h020, 64'd1);
    rd_m("count_after_reload0", 12'h010);
    rd_m("count_after_reload1", 12'h010);
    rd_m("count_after_reload2", 12'h010);
    wr(12'h020, 64'd1);
    idle_n(3);

    // Byte write into a running counter
    wr(12'h000, 64'd0);
    wr(12'h010, 64'h10);
    wr(12'h020, 64'd1);
    wr(12'h000, 64'd1);
    idle_n(3);
    cyc(mk(1'b1, 2'b10, 1'b1, 12'h013, 3'd0, 64'h0000_0000_AB00_0000), "", 1'b0, 64'd0);
    rd_m("count_byte_write", 12'h010);
    rd_m("count_after_byte", 12'h010);

    // 64-bit wrap does not raise MATCH
    wr(12'h000, 64'd0);
    wr(12'h018, 64'd5);
    wr(12'h008, 64'd0);
    wr(12'h010, 64'hFFFF_FFFF_FFFF_FFFF);
    wr(12'h020, 64'd1);
    wr(12'h000, 64'd1);
    rd_m("count_wrap_pre", 12'h010);
    rd_c("status_after_wrap", 12'h020, 64'd0);
    rd_m("count_wrap_post", 12'h010);

    // W1C landing on the same edge as a new match
    wr(12'h000, 64'd0);
    wr(12'h010, 64'd0);
    wr(12'h020, 64'd1);
    wr(12'h000, 64'd3);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (m_ctrl[0] && m_count == 64'd4) begin found = 1'b1; break; end
      idle_n(1);
    end
    if (!found) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_count4: got count %h expected 4 within 20 cycles", m_count);
    end
    wr(12'h020, 64'd1);
    idle_n(1);
    rd_c("status_w1c_collision", 12'h020, 64'd1);
    idle_n(1);

    // Reset arriving during a write data phase
    wr(12'h018, 64'h99);
    HWDATA = dp.wdata; HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    model_reset();
    dp = mk(1'b0, 2'b00, 1'b0, 12'h0, 3'd0, 64'd0);
    dp_act = 1'b0;
    #1;
    reset = 1'b0;
    rd_c("compare_reset_discard", 12'h018, 64'd0);
    rd_c("ctrl_after_reset", 12'h000, 64'd0);
    idle_n(2);

    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
